// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: data/opcode widths and the
// legal opcode set.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4
  } alu_op_e;

  // Opcodes above XOR are reserved and flagged as illegal.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op > OP_W'(OP_XOR);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU; reserved opcodes produce a zero result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // NOTE: result gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; the winner's result is held in a single
// response slot until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
);

  logic              last_grant;
  logic              slot_free;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  assign slot_free = !rsp_valid || rsp_ready;

  // Port 1 wins when alone, or in round-robin mode when port 0 went last.
  assign grant1 = req1_valid && (!req0_valid || (RR_EN && !last_grant));

  assign req0_ready = !rst && slot_free && req0_valid && !grant1;
  assign req1_ready = !rst && slot_free && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;
  assign sel_op = grant1 ? req1_op : req0_op;

  alu_arbiter_alu u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .op     (sel_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      last_grant  <= 1'b1;
    end else if (accept) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= grant1;
      rsp_result  <= alu_result;
      rsp_zero    <= alu_zero;
      rsp_illegal <= is_illegal_op(sel_op);
      last_grant  <= grant1;
    end else if (rsp_ready) begin
      // Payload fields keep their last values after a drain.
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share the
// same stimulus and are compared against an abstract transaction model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;

  logic [1:0]  rdy0_o, rdy1_o, rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_ill_o;
  logic [31:0] rsp_result_o [2];

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rdy0_o[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(rdy1_o[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_o[0]),
    .rsp_result(rsp_result_o[0]), .rsp_zero(rsp_zero_o[0]), .rsp_illegal(rsp_ill_o[0])
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rdy0_o[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(rdy1_o[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_o[1]),
    .rsp_result(rsp_result_o[1]), .rsp_zero(rsp_zero_o[1]), .rsp_illegal(rsp_ill_o[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one entry per instance (0 = round-robin, 1 = fixed).
  bit          m_valid [2];
  bit          m_id    [2];
  logic [31:0] m_result[2];
  bit          m_zero  [2];
  bit          m_ill   [2];
  bit          m_last  [2];
  int          m_grant [2];
  bit          s_rdy0  [2];
  bit          s_rdy1  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd1:    return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // -1: nobody granted, otherwise the winning port.
  function automatic int ref_grant(input bit v0, input bit v1, input bit last, input bit rr);
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (!v0 && v1)  return 1;
    if (rr)         return last ? 0 : 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_id[i] = 0; m_result[i] = '0;
      m_zero[i] = 0; m_ill[i] = 0; m_last[i] = 1;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [3:0] op;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      m_grant[i] = -1;
      if (!rst && (!m_valid[i] || rsp_ready))
        m_grant[i] = ref_grant(req0_valid, req1_valid, m_last[i], i == 0);
      check($sformatf("u%0d req0_ready", i), 32'(rdy0_o[i]), 32'(m_grant[i] == 0));
      check($sformatf("u%0d req1_ready", i), 32'(rdy1_o[i]), 32'(m_grant[i] == 1));
      check($sformatf("u%0d rsp_valid", i), 32'(rsp_valid_o[i]), 32'(m_valid[i]));
      check($sformatf("u%0d rsp_id", i), 32'(rsp_id_o[i]), 32'(m_id[i]));
      check($sformatf("u%0d rsp_result", i), rsp_result_o[i], m_result[i]);
      check($sformatf("u%0d rsp_zero", i), 32'(rsp_zero_o[i]), 32'(m_zero[i]));
      check($sformatf("u%0d rsp_illegal", i), 32'(rsp_ill_o[i]), 32'(m_ill[i]));
      s_rdy0[i] = rdy0_o[i];
      s_rdy1[i] = rdy1_o[i];
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        if (m_grant[i] >= 0) begin
          op          = (m_grant[i] == 1) ? req1_op : req0_op;
          m_result[i] = (m_grant[i] == 1) ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
          m_valid[i]  = 1;
          m_id[i]     = (m_grant[i] == 1);
          m_zero[i]   = (m_result[i] == 0);
          m_ill[i]    = (op >= 4'd5);
          m_last[i]   = (m_grant[i] == 1);
        end else if (rsp_ready) begin
          m_valid[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    cycle(); cycle();
    rst = 0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        zero, ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{4'd0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0});
    vecs.push_back('{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0});
    vecs.push_back('{4'd1, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0});
    vecs.push_back('{4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0});
    vecs.push_back('{4'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1'b0});
    vecs.push_back('{4'd3, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0, 1'b0});
    vecs.push_back('{4'd4, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 1'b0});
    vecs.push_back('{4'd4, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0});
    vecs.push_back('{4'd9, 32'd1,          32'd1,          32'd0,          1'b1, 1'b1});
    vecs.push_back('{4'd15, 32'hDEAD_BEEF, 32'h1,          32'd0,          1'b1, 1'b1});

    rst = 1; idle_inputs();
    @(posedge clk); #1;
    model_reset();
    do_reset();

    // First cycle after reset release: port 0 ADD 5+7.
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0;
    cycle();
    check("first accept req0_ready", 32'(s_rdy0[0]), 32'd1);
    req0_valid = 0;
    check("first rsp_valid", 32'(rsp_valid_o[0]), 32'd1);
    check("first rsp_id", 32'(rsp_id_o[0]), 32'd0);
    check("first rsp_result", rsp_result_o[0], 32'd12);
    check("first rsp_zero", 32'(rsp_zero_o[0]), 32'd0);
    cycle();

    // Opcode table through port 0.
    foreach (vecs[k]) begin
      req0_valid = 1; req0_op = vecs[k].op; req0_a = vecs[k].a; req0_b = vecs[k].b;
      rsp_ready = 1;
      cycle();
      req0_valid = 0;
      check($sformatf("vec%0d result", k), rsp_result_o[0], vecs[k].res);
      check($sformatf("vec%0d zero", k), 32'(rsp_zero_o[0]), 32'(vecs[k].zero));
      check($sformatf("vec%0d illegal", k), 32'(rsp_ill_o[0]), 32'(vecs[k].ill));
    end
    cycle();

    // Contention after reset: round-robin alternates, fixed priority keeps port 0.
    do_reset();
    req0_valid = 1; req0_op = 4'd0; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1; req1_op = 4'd3; req1_a = 32'd20; req1_b = 32'd2;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("rr grant %0d rsp_id", k), 32'(rsp_id_o[0]), 32'(k % 2));
      check($sformatf("fp grant %0d rsp_id", k), 32'(rsp_id_o[1]), 32'd0);
      check($sformatf("fp grant %0d req1_ready", k), 32'(s_rdy1[1]), 32'd0);
    end

    // Consumer stall with both ports requesting.
    do_reset();
    req0_valid = 1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
    cycle();
    rsp_ready = 0;
    req1_valid = 1; req1_op = 4'd1; req1_a = 32'd9; req1_b = 32'd4;
    req0_op = 4'd2;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("stall %0d ready0", k), 32'(s_rdy0[0]), 32'd0);
      check($sformatf("stall %0d ready1", k), 32'(s_rdy1[0]), 32'd0);
      check($sformatf("stall %0d result", k), rsp_result_o[0], 32'd3);
    end
    rsp_ready = 1;
    cycle();
    check("stall release single grant", 32'(s_rdy0[0]) + 32'(s_rdy1[0]), 32'd1);
    check("stall release rsp_id", 32'(rsp_id_o[0]), 32'd1);
    check("stall release result", rsp_result_o[0], 32'd5);

    // Drain without a new accept, then reset while a response is held.
    req0_valid = 0; req1_valid = 0;
    cycle();
    check("drain rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
    check("drain result held", rsp_result_o[0], 32'd5);
    req0_valid = 1; req0_op = 4'd0; req0_a = 32'd4; req0_b = 32'd4;
    rsp_ready = 0;
    cycle();
    check("pre-reset rsp_valid", 32'(rsp_valid_o[0]), 32'd1);
    rst = 1; req1_valid = 1;
    cycle();
    check("reset rsp_valid rr", 32'(rsp_valid_o[0]), 32'd0);
    check("reset rsp_valid fp", 32'(rsp_valid_o[1]), 32'd0);
    rst = 0; idle_inputs();
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 49) == 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req0_op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      req1_op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      req0_a     = $urandom;
      req0_b     = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
      req1_a     = $urandom;
      req1_b     = ($urandom_range(0, 7) == 0) ? req1_a : $urandom;
      cycle();
    end
    rst = 0; idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
